// File: rtl/link_power_sequencer.sv
// Power-up sequencer and link supervisor: rails -> LNA -> split radio -> link-up,
// with rail/activity supervision, bounded power-cycle retries and a latched fault.
module link_power_sequencer #(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int RAIL_TIMEOUT    = 5000,
  parameter int LNA_WARMUP      = 500,
  parameter int LINK_TIMEOUT    = 100000,
  parameter int ACTIVITY_WINDOW = 4096,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 20
) (
  input  logic       Clock100Mhz,
  input  logic       ResetN,
  input  logic       Enable,
  input  logic       VplusGood,
  input  logic       VminusGood,
  input  logic       Received1236,
  input  logic       Received4578,
  output logic       RailEnable,
  output logic       LnaEnable,
  output logic       SplitEnable,
  output logic       LinkUp,
  output logic       Fault,
  output logic [2:0] State,
  output logic [1:0] RetryCount
);

  typedef enum logic [2:0] {
    ST_OFF         = 3'd0,
    ST_RAIL_UP     = 3'd1,
    ST_RAIL_SETTLE = 3'd2,
    ST_LNA_WARM    = 3'd3,
    ST_SPLIT_ON    = 3'd4,
    ST_LINK_WAIT   = 3'd5,
    ST_LINK_UP     = 3'd6,
    ST_FAULT       = 3'd7
  } state_t;

  // The counter reads 0 in the first cycle of a state, so an N-cycle dwell ends at N-1.
  localparam logic [CNT_W-1:0] SETTLE_C   = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARM_END   = CNT_W'(LNA_WARMUP - 1);
  localparam logic [CNT_W-1:0] RAIL_TO_C  = CNT_W'(RAIL_TIMEOUT);
  localparam logic [CNT_W-1:0] LINK_TO_C  = CNT_W'(LINK_TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_END   = CNT_W'(ACTIVITY_WINDOW - 1);
  localparam logic [1:0]       MAX_R      = 2'(MAX_RETRY);

  logic [3:0]       async_in;
  logic [3:0]       sync1_reg, sync2_reg;
  logic [1:0]       pair_d_reg;
  logic [1:0]       pair_edge, seen_reg, seen_next, idle_hit;
  logic             rails_ok, retry_req;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       retry_reg, retry_next;
  logic [4:0]       outs_reg, outs_next;

  assign async_in = {Received4578, Received1236, VminusGood, VplusGood};

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      pair_d_reg <= '0;
    end else begin
      sync1_reg  <= async_in;
      sync2_reg  <= sync1_reg;
      pair_d_reg <= sync2_reg[3:2];
    end
  end

  assign rails_ok  = sync2_reg[0] & sync2_reg[1];
  assign pair_edge = sync2_reg[3:2] ^ pair_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      logic [CNT_W-1:0] idle_reg, idle_next;

      // Seen flags only accumulate while waiting for the link; elsewhere they sit cleared.
      assign seen_next[gi] = (state_reg == ST_LINK_WAIT) & (seen_reg[gi] | pair_edge[gi]);
      assign idle_hit[gi]  = ~pair_edge[gi] & (idle_reg == IDLE_END);

      always_comb begin
        idle_next = '0;
        if (state_reg == ST_LINK_UP && state_next == ST_LINK_UP && !pair_edge[gi])
          idle_next = (idle_reg == '1) ? idle_reg : idle_reg + CNT_W'(1);
      end

      always_ff @(posedge Clock100Mhz or negedge ResetN) begin
        if (!ResetN) idle_reg <= '0;
        else         idle_reg <= idle_next;
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    retry_req  = 1'b0;
    if (!Enable) begin
      state_next = ST_OFF;
      retry_next = '0;
    end else begin
      case (state_reg)
        ST_OFF:         if (cnt_reg >= SETTLE_C) state_next = ST_RAIL_UP;
        ST_RAIL_UP:     if (rails_ok) state_next = ST_RAIL_SETTLE;
                        else if (cnt_reg == RAIL_TO_C) retry_req = 1'b1;
        ST_RAIL_SETTLE: if (!rails_ok) retry_req = 1'b1;
                        else if (cnt_reg == SETTLE_END) state_next = ST_LNA_WARM;
        ST_LNA_WARM:    if (!rails_ok) retry_req = 1'b1;
                        else if (cnt_reg == WARM_END) state_next = ST_SPLIT_ON;
        ST_SPLIT_ON:    if (!rails_ok) retry_req = 1'b1;
                        else state_next = ST_LINK_WAIT;
        ST_LINK_WAIT:   if (!rails_ok) retry_req = 1'b1;
                        else if (&(seen_reg | pair_edge)) state_next = ST_LINK_UP;
                        else if (cnt_reg == LINK_TO_C) retry_req = 1'b1;
        ST_LINK_UP:     if (!rails_ok || (|idle_hit)) retry_req = 1'b1;
        default:        state_next = state_reg;
      endcase
      if (retry_req) begin
        if (retry_reg == MAX_R) begin
          state_next = ST_FAULT;
        end else begin
          state_next = ST_OFF;
          retry_next = (retry_reg == 2'd3) ? retry_reg : retry_reg + 2'd1;
        end
      end
    end
  end

  always_comb begin
    cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
    if (state_next != state_reg) cnt_next = '0;
  end

  // Output bits: {rail, lna, split, linkup, fault}, decoded ahead so they change with State.
  always_comb begin
    outs_next = 5'b00000;
    case (state_next)
      ST_RAIL_UP, ST_RAIL_SETTLE: outs_next = 5'b10000;
      ST_LNA_WARM:                outs_next = 5'b11000;
      ST_SPLIT_ON, ST_LINK_WAIT:  outs_next = 5'b11100;
      ST_LINK_UP:                 outs_next = 5'b11110;
      ST_FAULT:                   outs_next = 5'b00001;
      default:                    outs_next = 5'b00000;
    endcase
  end

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      state_reg <= ST_OFF;
      cnt_reg   <= '0;
      retry_reg <= '0;
      seen_reg  <= '0;
      outs_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      seen_reg  <= seen_next;
      outs_reg  <= outs_next;
    end
  end

  assign {RailEnable, LnaEnable, SplitEnable, LinkUp, Fault} = outs_reg;
  assign State      = state_reg;
  assign RetryCount = retry_reg;

endmodule
